// File: rtl/monitor_temp_multicanal_pkg.sv
// Shared types and helpers for the multichannel temperature monitor:
// FSM encoding, channel-index width and the sensor fault code.
package monitor_temp_multicanal_pkg;

   typedef enum logic [1:0] {
      ESPERA  = 2'b00,
      LEER    = 2'b01,
      DECIDIR = 2'b10,
      ALERTA  = 2'b11
   } estado_t;

   // Channel index width, never narrower than one bit.
   function automatic int ancho_canal(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // All-ones sample of a tw-bit sensor marks a broken channel.
   function automatic logic [31:0] codigo_falla(input int tw);
      return (32'd1 << tw) - 32'd1;
   endfunction

endpackage

// File: rtl/monitor_temp_multicanal_if.sv
// Sensor/actuator bundle of the temperature monitor; slave side is the monitor,
// master side is whoever feeds samples and consumes the commands.
interface monitor_temp_multicanal_if #(
   parameter int N_CH = 4,
   parameter int TW   = 5
);
   import monitor_temp_multicanal_pkg::*;

   localparam int CW = ancho_canal(N_CH);

   logic [N_CH*TW-1:0] Temperatura;
   logic               DatosListos;
   logic               Presencia;
   logic               Ignicion;
   logic               Ventilacion;
   logic               Alarma;
   logic               Peligro;
   logic [TW-1:0]      TempMax;
   logic [CW-1:0]      CanalMax;
   logic [1:0]         Estados;
   logic [N_CH-1:0]    Falla;

   modport master (
      output Temperatura, DatosListos, Presencia, Ignicion,
      input  Ventilacion, Alarma, Peligro, TempMax, CanalMax, Estados, Falla
   );

   modport slave (
      input  Temperatura, DatosListos, Presencia, Ignicion,
      output Ventilacion, Alarma, Peligro, TempMax, CanalMax, Estados, Falla
   );

endinterface

// File: rtl/monitor_temp_multicanal_comparador.sv
// Hysteresis level: sets at valor >= UMBRAL (when confirmar), clears below UMBRAL-HYST.
// nivel shows the freshly computed level during the actualizar cycle, the held level otherwise.
module comparador_histeresis #(
   parameter int TW     = 5,
   parameter int UMBRAL = 20,
   parameter int HYST   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [TW-1:0] valor,
   input  logic          actualizar,
   input  logic          confirmar,
   output logic          nivel
);
   localparam logic [TW:0] K_ALTO = (TW+1)'(UMBRAL);
   localparam logic [TW:0] K_BAJO = (TW+1)'(UMBRAL - HYST);

   logic          r_nivel;
   logic          w_nivel_sig;
   logic [TW:0]   w_valor;

   assign w_valor = {1'b0, valor};

   always_comb begin
      w_nivel_sig = r_nivel;
      if (confirmar && (w_valor >= K_ALTO))
         w_nivel_sig = 1'b1;
      else if (w_valor < K_BAJO)
         w_nivel_sig = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_nivel <= 1'b0;
      else if (actualizar)
         r_nivel <= w_nivel_sig;
   end

   assign nivel = actualizar ? w_nivel_sig : r_nivel;

endmodule

// File: rtl/monitor_temp_multicanal.sv
// Scans N_CH latched samples one per cycle for the hottest channel, then updates fan/alarm
// levels; results land N_CH+1 cycles after the strobe. Fault skipping: MONITOR_FALLA_SENSOR_EN.
module monitor_temp_multicanal
   import monitor_temp_multicanal_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int TW      = 5,
   parameter int T_VENT  = 20,
   parameter int T_ALARM = 28,
   parameter int HYST    = 2,
   parameter int N_CONF  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   monitor_temp_multicanal_if.slave bus
);
   localparam int CW = ancho_canal(N_CH);
   localparam int NW = $clog2(N_CONF + 1);
   localparam logic [CW-1:0] K_ULT   = CW'(N_CH - 1);
   localparam logic [NW-1:0] K_CONF  = NW'(N_CONF);
   localparam logic [TW:0]   K_ALARM = (TW+1)'(T_ALARM);

   estado_t          r_estado, w_estado_sig;
   logic [TW-1:0]    r_muestra [N_CH];
   logic [CW-1:0]    r_idx, r_canal, r_cmax;
   logic [TW-1:0]    r_max, r_tmax;
   logic             r_hallado, r_vent, r_alarma, r_peligro;
   logic [NW-1:0]    r_cont;
   logic [N_CH-1:0]  r_falla;

   logic [N_CH-1:0]  w_falla_vec;
   logic [TW-1:0]    w_cur, w_max_scan, w_max_eval;
   logic [CW-1:0]    w_canal_scan, w_canal_eval;
   logic             w_toma, w_hallado, w_final, w_vent_niv, w_pel_niv;
   logic [NW-1:0]    w_cont_sig;

`ifdef MONITOR_FALLA_SENSOR_EN
   localparam logic [TW-1:0] K_FALLA = TW'(codigo_falla(TW));
   always_comb begin
      w_falla_vec = '0;
      for (int c = 0; c < N_CH; c++)
         w_falla_vec[c] = (r_muestra[c] == K_FALLA);
   end
`else
   assign w_falla_vec = '0;
`endif

   // Strictly-greater keeps the lowest index on ties; the first valid channel always seeds the max.
   assign w_cur        = r_muestra[r_idx];
   assign w_toma       = !w_falla_vec[r_idx] && (!r_hallado || (w_cur > r_max));
   assign w_max_scan   = w_toma ? w_cur : r_max;
   assign w_canal_scan = w_toma ? r_idx : r_canal;
   assign w_hallado    = r_hallado | !w_falla_vec[r_idx];
   assign w_max_eval   = w_hallado ? w_max_scan : '0;
   assign w_canal_eval = w_hallado ? w_canal_scan : '0;
   assign w_final      = (r_estado == DECIDIR) && (r_idx == K_ULT);

   always_comb begin
      w_cont_sig = '0;
      if (w_hallado && ({1'b0, w_max_eval} >= K_ALARM))
         w_cont_sig = (r_cont == K_CONF) ? r_cont : r_cont + NW'(1);
   end

   comparador_histeresis #(.TW(TW), .UMBRAL(T_VENT), .HYST(HYST)) u_vent (
      .clk(clk), .rst(rst), .valor(w_max_eval), .actualizar(w_final),
      .confirmar(1'b1), .nivel(w_vent_niv)
   );

   comparador_histeresis #(.TW(TW), .UMBRAL(T_ALARM), .HYST(HYST)) u_peligro (
      .clk(clk), .rst(rst), .valor(w_max_eval), .actualizar(w_final),
      .confirmar(w_cont_sig == K_CONF), .nivel(w_pel_niv)
   );

   always_comb begin
      w_estado_sig = r_estado;
      case (r_estado)
         ESPERA, ALERTA: if (bus.DatosListos) w_estado_sig = LEER;
         LEER:           w_estado_sig = DECIDIR;
         DECIDIR:        if (r_idx == K_ULT) w_estado_sig = w_pel_niv ? ALERTA : ESPERA;
         default:        w_estado_sig = ESPERA;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_estado <= ESPERA;
      else
         r_estado <= w_estado_sig;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < N_CH; c++) r_muestra[c] <= '0;
         r_idx     <= '0;
         r_canal   <= '0;
         r_max     <= '0;
         r_hallado <= 1'b0;
         r_cont    <= '0;
         r_tmax    <= '0;
         r_cmax    <= '0;
         r_vent    <= 1'b0;
         r_alarma  <= 1'b0;
         r_peligro <= 1'b0;
         r_falla   <= '0;
      end else if (r_estado == LEER) begin
         for (int c = 0; c < N_CH; c++) r_muestra[c] <= bus.Temperatura[c*TW +: TW];
         r_idx     <= '0;
         r_canal   <= '0;
         r_max     <= '0;
         r_hallado <= 1'b0;
      end else if (r_estado == DECIDIR) begin
         r_max     <= w_max_scan;
         r_canal   <= w_canal_scan;
         r_hallado <= w_hallado;
         r_idx     <= r_idx + CW'(1);
         if (w_final) begin
            r_tmax    <= w_max_eval;
            r_cmax    <= w_canal_eval;
            r_cont    <= w_cont_sig;
            r_vent    <= w_vent_niv & bus.Ignicion;
            r_peligro <= w_pel_niv;
            r_alarma  <= w_pel_niv & bus.Presencia;
            r_falla   <= w_falla_vec;
         end
      end
   end

   assign bus.Ventilacion = r_vent;
   assign bus.Alarma      = r_alarma;
   assign bus.Peligro     = r_peligro;
   assign bus.TempMax     = r_tmax;
   assign bus.CanalMax    = r_cmax;
   assign bus.Estados     = r_estado;
   assign bus.Falla       = r_falla;

endmodule
